// File: rtl/alu_seq_pkg.sv
// Shared widths, ALU op codes and sequencer state type for alu_sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W   = 4;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned CNT_W    = 4;

    // Control code bit 2 = L, bit 1 = M, bit 0 = N on the ALU.
    localparam logic [OP_W-1:0] OP_NEGA = 3'b000;
    localparam logic [OP_W-1:0] OP_NEGB = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OP_W-1:0] OP_AND  = 3'b100;
    localparam logic [OP_W-1:0] OP_OR   = 3'b101;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b110;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b111;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SETTLE = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x4 register file: two combinational read ports, one synchronous write port
// shared between loads and ALU write-back.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] rd_addr_a_i,
    input  logic [ADDR_W-1:0] rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    output logic [DATA_W-1:0] rd_data_b_o,
    input  logic              load_we_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    assign rd_data_a_o = regs_q[rd_addr_a_i];
    assign rd_data_b_o = regs_q[rd_addr_b_i];

    // Loads only happen in IDLE and write-back only leaves SETTLE, so the two
    // enables are never high together; load still wins if they were.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (load_we_i) begin
            regs_q[load_addr_i] <= load_data_i;
        end else if (wb_we_i) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Initiator-side sequencer for the 4-bit ripple ALU. Optional result flags
// (res_zero/res_neg) are built when ALU_SEQ_FLAGS_EN is defined.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [ADDR_W-1:0] instr_ra,
    input  logic [ADDR_W-1:0] instr_rb,
    input  logic [ADDR_W-1:0] instr_rd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_c,
    input  logic [DATA_W-1:0] alu_s,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0] res_rd
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic              res_zero,
    output logic              res_neg
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_c_q, alu_c_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [ADDR_W-1:0] res_rd_q, res_rd_d;
`ifdef ALU_SEQ_FLAGS_EN
    logic              res_zero_q, res_zero_d;
    logic              res_neg_q, res_neg_d;
`endif

    logic              load_we;
    logic              wb_we;
    logic [DATA_W-1:0] rf_data_a;
    logic [DATA_W-1:0] rf_data_b;

    alu_seq_regfile u_regfile (
        .clk_i       (clk),
        .reset_i     (reset),
        .rd_addr_a_i (instr_ra),
        .rd_addr_b_i (instr_rb),
        .rd_data_a_o (rf_data_a),
        .rd_data_b_o (rf_data_b),
        .load_we_i   (load_we),
        .load_addr_i (load_addr),
        .load_data_i (load_data),
        .wb_we_i     (wb_we),
        .wb_addr_i   (rd_q),
        .wb_data_i   (alu_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_c_d     = alu_c_q;
        rd_d        = rd_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
`ifdef ALU_SEQ_FLAGS_EN
        res_zero_d  = res_zero_q;
        res_neg_d   = res_neg_q;
`endif
        load_we     = 1'b0;
        wb_we       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (load_valid) begin
                    load_we = 1'b1;
                end else if (instr_valid) begin
                    alu_a_d = rf_data_a;
                    alu_b_d = rf_data_b;
                    alu_c_d = instr_op;
                    rd_d    = instr_rd;
                    cnt_d   = SETTLE_INIT;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    res_data_d  = alu_s;
                    res_rd_d    = rd_q;
                    res_valid_d = 1'b1;
                    wb_we       = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                    res_zero_d  = (alu_s == '0);
                    res_neg_d   = alu_s[DATA_W-1];
`endif
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_c_q     <= '0;
            rd_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            res_zero_q  <= 1'b0;
            res_neg_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_c_q     <= alu_c_d;
            rd_q        <= rd_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
`ifdef ALU_SEQ_FLAGS_EN
            res_zero_q  <= res_zero_d;
            res_neg_q   <= res_neg_d;
`endif
        end
    end

    assign load_ready  = (state_q == S_IDLE);
    assign instr_ready = (state_q == S_IDLE) && !load_valid;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_c       = alu_c_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_rd      = res_rd_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign res_zero    = res_zero_q;
    assign res_neg     = res_neg_q;
`endif

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Initiator-side controller for the 4-bit combinational ALU: accepts register-addressed instructions over a valid/ready handshake, drives the ALU operand buses and 3-bit control code from a 4-entry 4-bit register file, waits a configurable settle time for the ripple datapath, then captures the ALU output and writes it back. The block sits upstream of the ALU as its only driver and feeds results to a downstream consumer or a bench.

## Interface
- SETTLE_CYCLES, 2, cycles the ALU output is allowed to settle before capture; legal range 1..15.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  request to write load_data into register load_addr.
- load_ready  out  1  high only in IDLE.
- load_addr  in  2  destination register of a load.
- load_data  in  4  value to load.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  IDLE and not load_valid.
- instr_op  in  3  ALU control code, bit 2 = L, bit 1 = M, bit 0 = N.
- instr_ra, instr_rb, instr_rd  in  2 each  source A, source B, destination register.
- alu_a, alu_b  out  4 each  registered operands to ALU inputs A, B.
- alu_c  out  3  registered control code to ALU L/M/N.
- alu_s  in  4  ALU result S.
- res_valid  out  1  one-cycle pulse: result captured and written.
- res_data  out  4  captured result.
- res_rd  out  2  register written by this result.

## Operation
- Op codes: 000 -A, 001 -B, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 A*B (low 4 bits), 111 A^B. All arithmetic mod 16, two's complement; no carry/overflow observed.
- States: IDLE, SETTLE.
- IDLE: load accepted on load_valid (writes R[load_addr]); load has priority, so instr_ready is low that cycle. Instruction accepted on instr_valid && instr_ready: alu_a <= R[ra], alu_b <= R[rb], alu_c <= op, latch rd, cnt <= SETTLE_CYCLES, go SETTLE.
- SETTLE: cnt decrements each edge; on the edge where cnt == 1: res_data <= alu_s, R[rd] <= alu_s, res_rd <= rd, res_valid <= 1, go IDLE.
- alu_a/b/c hold their values after capture until the next accept.
- Load while in SETTLE: not accepted (load_ready low); requester must hold load_valid.
- ra == rb legal; rd equal to a source legal (sources already latched).
- Reset values: all R = 0, alu_a = alu_b = 0, alu_c = 000, res_valid = 0, res_data = 0, res_rd = 0, cnt = 0, state IDLE. Reset mid-SETTLE aborts: no write-back, no res_valid.

## Timing
- Accept at edge E0; capture and write-back at edge E(SETTLE_CYCLES); res_valid high for the cycle after that edge.
- instr_ready high again in the res_valid cycle; earliest next accept E(SETTLE_CYCLES+1), which reads the just-written value (no hazard).
- Throughput: one instruction per SETTLE_CYCLES+1 cycles.
- ALU operands stable for SETTLE_CYCLES full cycles before capture.

## Configuration
- ALU_SEQ_FLAGS_EN defined: adds outputs res_zero (1, res_data == 0) and res_neg (1, res_data[3]), registered on the capture edge alongside res_data, reset to 0.
- Undefined: those ports and registers do not exist; all other behaviour identical.

## Structure
- Package alu_seq_pkg: op code constants (OP_NEGA, OP_NEGB, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_XOR), state type, register address width 2, data width 4.
- Sub-module alu_seq_regfile: 4x4 registers, two combinational read ports, one synchronous write port with write-select between load and write-back (never simultaneous by construction), synchronous reset to zero.
- ALU is instantiated outside this block; the bench connects alu_a/alu_b/alu_c/alu_s to it.

## Test plan
- Reset, load R0=3, R1=5, op 010 ra=0 rb=1 rd=2 -> res_valid at E2 (SETTLE_CYCLES=2), res_data 8, res_rd 2, R2 = 8.
- Same operands, op 011 -> 4'b1110; op 110 -> 4'b1111; op 111 -> 4'b0110; op 000 with R0=0 -> 0.
- Multiply wrap: R0=R1=5, op 110 -> 4'b1001; with ALU_SEQ_FLAGS_EN, op 011 ra=rb=0 -> res_data 0, res_zero 1, res_neg 0.
- Back-to-back: second instruction ra=2 issued in res_valid cycle of the first -> alu_a equals first result; load_valid asserted during SETTLE -> load_ready low, register unchanged until IDLE.
- Reset asserted one cycle after accept -> no res_valid, all registers and outputs return to reset values.
- SETTLE_CYCLES=1 and 15 -> capture at E1 and E15 respectively, alu_c stable throughout.
